sha3_pad_packer: RTL
====================

// Module: sha3_pad_packer
// PURPOSE
//  Multi-mode SHA3/SHAKE message packer and padder ahead of the Keccak permutation core.
//  Packs streamed message beats into a rate-sized block.
//  Applies FIPS 202 domain-separation and pad10*1 padding.
//  Hands each block to the core over a valid/ready handshake.
//  Mode is selectable per message: SHA3-224/256/384/512, SHAKE128/256.
// PARAMETERS
//  DW       32    message beat width in bits; legal values 32 or 64
//  MAX_RATE 1344  block output width in bits; covers the largest rate (SHAKE128)
// PORTS
//  clk          in   1           clock
//  rst_b        in   1           asynchronous active-low reset
//  start_i      in   1           pulse: latch mode_i and begin a new message; honoured only in IDLE
//  mode_i       in   3           0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256
//  msg_valid_i  in   1           message beat valid
//  msg_data_i   in   DW          message beat; byte k is at [8k+:8]
//  msg_strb_i   in   DW/8        byte enables; must be contiguous from bit 0
//  msg_last_i   in   1           final beat of the message
//  msg_ready_o  out  1           beat accepted when msg_valid_i && msg_ready_o
//  blk_valid_o  out  1           block available
//  blk_data_o   out  MAX_RATE    block; message byte j of block at [8j+:8]; bytes >= rate are zero
//  blk_last_o   out  1           block carries the padding (final block of the message)
//  blk_ready_i  in   1           core accepts block when blk_valid_o && blk_ready_i
//  busy_o       out  1           state != IDLE
//  err_o        out  1           sticky protocol/mode error; cleared by the next accepted start_i
// BEHAVIOUR
//  Reset state:
//   - All outputs 0; buffer zeroed; byte count 0; FSM in IDLE.
//   - Async reset mid-message discards all state; no partial block is emitted.
//  Rate in bytes by mode: 144, 136, 104, 72, 168, 136.
//  Domain byte: 0x06 for SHA3 modes, 0x1F for SHAKE modes.
//  FSM states: IDLE, FILL, OUT, PAD, OUTLAST.
//  IDLE:
//   - On start_i with a legal mode: latch mode, clear buffer and count, clear err_o, go to FILL.
//   - On start_i with mode 6 or 7: set err_o=1 and stay in IDLE.
//  FILL:
//   - msg_ready_o=1. An accepted beat writes its enabled bytes at offset cnt; cnt += popcount(strb).
//   - Illegal strobes are a non-contiguous strb, or a partial strb without last. On either:
//     set err_o, drop the beat, leave cnt unchanged.
//   - cnt reaches rate on a non-last beat: go to OUT.
//   - Last beat leaves cnt < rate: go to PAD.
//   - Last beat makes cnt == rate: go to OUT with pad_pending=1.
//   - msg_last_i with strb==0 is legal and contributes 0 bytes (empty message, or a trailing empty beat).
//  Beat alignment:
//   - Every rate is a multiple of 8 bytes, so a full beat never straddles a block boundary.
//  OUT:
//   - blk_valid_o=1, blk_last_o=0, msg_ready_o=0.
//   - On blk_ready_i: clear buffer and cnt; go to PAD if pad_pending, else FILL.
//  PAD (one cycle):
//   - buffer[cnt] ^= domain byte; buffer[rate-1] ^= 0x80.
//   - When cnt == rate-1 these combine to 0x86 or 0x9F.
//   - Go to OUTLAST.
//  OUTLAST:
//   - blk_valid_o=1, blk_last_o=1.
//   - On blk_ready_i: clear buffer and cnt, go to IDLE.
//  Handshake:
//   - blk_data_o, blk_valid_o and blk_last_o are registered and held stable while blk_valid_o && !blk_ready_i.
//   - blk_valid_o never drops before the handshake completes.
//  Latency:
//   - Beat that fills a block: blk_valid_o rises the next cycle.
//   - Last beat that does not fill a block: blk_valid_o rises 2 cycles after acceptance (via PAD).
//  Other cases:
//   - start_i outside IDLE is ignored.
//   - msg_valid_i outside FILL is not accepted.
//   - mode_i changes after start have no effect.
// TESTING
//  SHA3-256, start then last with strb=0 -> one block, last=1, byte0=0x06, byte135=0x80, all others 0.
//  SHA3-256, 135 bytes 0xAA (33 full beats + 3-byte last) -> one block, bytes0..134=0xAA, byte135=0x86.
//  SHAKE128, 168 bytes (42 full beats, DW=32) -> block1 last=0 holds the data; then block2 last=1, byte0=0x1F, byte167=0x80.
//  SHA3-512, 72 bytes with blk_ready_i low for 5 cycles -> blk_data_o stable, msg_ready_o=0 throughout, then padding block follows.
//  start_i with mode_i=7 -> err_o=1, busy_o=0. Next start with mode 1 -> err_o=0, busy_o=1.
//  Reset asserted after 10 beats in FILL -> all outputs 0 immediately; a subsequent empty SHA3-224 message gives byte143=0x80.

Source files
------------

// File: rtl/sha3_pad_packer.sv
// Packs message beats into rate-sized Keccak blocks and applies FIPS 202 domain bits and
// pad10*1 padding. Blocks leave over a registered valid/ready handshake.
module sha3_pad_packer #(
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_RATE = 1344
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                start_i,
   input  logic [2:0]          mode_i,
   input  logic                msg_valid_i,
   input  logic [DW-1:0]       msg_data_i,
   input  logic [DW/8-1:0]     msg_strb_i,
   input  logic                msg_last_i,
   output logic                msg_ready_o,
   output logic                blk_valid_o,
   output logic [MAX_RATE-1:0] blk_data_o,
   output logic                blk_last_o,
   input  logic                blk_ready_i,
   output logic                busy_o,
   output logic                err_o
);

   localparam int unsigned NB       = DW / 8;
   localparam int unsigned MaxBytes = MAX_RATE / 8;

   typedef enum logic [2:0] {StIdle, StFill, StOut, StPad, StOutLast} state_e;

   state_e              state_q, state_d;
   logic [2:0]          mode_q, mode_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [MAX_RATE-1:0] buf_q, buf_d;
   logic                pend_q, pend_d;
   logic                err_q, err_d;

   logic [7:0] rate, dom, pop, cnt_new;
   logic       strb_contig, strb_ok;

   always_comb begin
      case (mode_q)
         3'd0:    rate = 8'd144;
         3'd1:    rate = 8'd136;
         3'd2:    rate = 8'd104;
         3'd3:    rate = 8'd72;
         3'd4:    rate = 8'd168;
         default: rate = 8'd136;
      endcase
      dom = (mode_q >= 3'd4) ? 8'h1F : 8'h06;
   end

   // Legal strobes are a run of ones from bit 0; a partial run is only allowed on the last beat.
   always_comb begin
      strb_contig = 1'b1;
      pop         = 8'd0;
      for (int unsigned k = 0; k < NB; k++) begin
         if (msg_strb_i[k]) pop = pop + 8'd1;
         if (k > 0 && msg_strb_i[k] && !msg_strb_i[k-1]) strb_contig = 1'b0;
      end
      strb_ok = strb_contig && ((&msg_strb_i) || msg_last_i);
      cnt_new = cnt_q + pop;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      pend_d  = pend_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               if (mode_i <= 3'd5) begin
                  mode_d  = mode_i;
                  cnt_d   = 8'd0;
                  buf_d   = '0;
                  pend_d  = 1'b0;
                  err_d   = 1'b0;
                  state_d = StFill;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StFill: begin
            if (msg_valid_i) begin
               if (!strb_ok) begin
                  err_d = 1'b1;
               end else begin
                  for (int unsigned k = 0; k < NB; k++) begin
                     if (msg_strb_i[k] && (32'(cnt_q) + k) < MaxBytes) begin
                        buf_d[8*(32'(cnt_q)+k) +: 8] = msg_data_i[8*k +: 8];
                     end
                  end
                  cnt_d = cnt_new;
                  if (cnt_new == rate) begin
                     state_d = StOut;
                     pend_d  = msg_last_i;
                  end else if (msg_last_i) begin
                     state_d = StPad;
                  end
               end
            end
         end
         StOut: begin
            if (blk_ready_i) begin
               buf_d   = '0;
               cnt_d   = 8'd0;
               pend_d  = 1'b0;
               state_d = pend_q ? StPad : StFill;
            end
         end
         StPad: begin
            // Both XORs land on the same byte when cnt == rate-1, giving 0x86 / 0x9F.
            if (32'(cnt_q) < MaxBytes) begin
               buf_d[8*32'(cnt_q) +: 8] = buf_d[8*32'(cnt_q) +: 8] ^ dom;
            end
            if (32'(rate) <= MaxBytes) begin
               buf_d[8*(32'(rate)-1) +: 8] = buf_d[8*(32'(rate)-1) +: 8] ^ 8'h80;
            end
            state_d = StOutLast;
         end
         StOutLast: begin
            if (blk_ready_i) begin
               buf_d   = '0;
               cnt_d   = 8'd0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= StIdle;
         mode_q  <= 3'd0;
         cnt_q   <= 8'd0;
         buf_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign msg_ready_o = (state_q == StFill);
   assign blk_valid_o = (state_q == StOut) || (state_q == StOutLast);
   assign blk_last_o  = (state_q == StOutLast);
   assign blk_data_o  = buf_q;
   assign busy_o      = (state_q != StIdle);
   assign err_o       = err_q;

endmodule
